// File: rtl/chs_pkg.sv
// ---------------------------------------------------------------------------
// chs_pkg
// Types and helpers for the cool/heat subsystem. The mode/power decoder
// and the thermostat controller both use it.
//   chs_state_t : 2-bit controller state (IDLE=0, HEAT=1, COOL=2)
//   sat_u8      : clamps a 16-bit unsigned value to the 0..255 range
// ---------------------------------------------------------------------------
package chs_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HEAT = 2'd1,
        ST_COOL = 2'd2
    } chs_state_t;

    // Clamp a 16-bit unsigned value to 8 bits.
    function automatic logic [7:0] sat_u8(input logic [15:0] value);
        logic [7:0] result;
        if (value > 16'd255) begin
            result = 8'd255;
        end else begin
            result = value[7:0];
        end
        return result;
    endfunction

endpackage

// File: rtl/temp_avg4.sv
// ---------------------------------------------------------------------------
// temp_avg4
// Moving average over the last four accepted temperature samples.
//   clk            : clock, posedge
//   arst           : asynchronous active-low reset
//   sample_valid_i : one-cycle strobe qualifying sample_i
//   sample_i       : unsigned sample, degrees C
//   avg_o          : registered sum of the last four samples >> 2
//   avg_valid_o    : high once four samples have been accepted
// ---------------------------------------------------------------------------
module temp_avg4 (
    input  logic       clk,
    input  logic       arst,
    input  logic       sample_valid_i,
    input  logic [7:0] sample_i,
    output logic [7:0] avg_o,
    output logic       avg_valid_o
);

    logic [7:0] buf_q [4];
    logic [9:0] sum_q;
    logic [9:0] sum_d;
    logic [2:0] cnt_q;
    logic       avg_valid_q;

    // Running sum: the newest sample enters and the oldest leaves.
    // The modular 10-bit arithmetic is exact because sum_q always contains buf_q[3].
    always_comb begin
        sum_d = sum_q + {2'b00, sample_i} - {2'b00, buf_q[3]};
    end

    // Sample shift register, running sum and saturating fill count.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            for (int i = 0; i < 4; i++) begin
                buf_q[i] <= 8'd0;
            end
            sum_q       <= 10'd0;
            cnt_q       <= 3'd0;
            avg_valid_q <= 1'b0;
        end else if (sample_valid_i) begin
            buf_q[0] <= sample_i;
            for (int i = 1; i < 4; i++) begin
                buf_q[i] <= buf_q[i-1];
            end
            sum_q <= sum_d;
            if (cnt_q != 3'd4) begin
                cnt_q <= cnt_q + 3'd1;
            end
            if (cnt_q >= 3'd3) begin
                avg_valid_q <= 1'b1;
            end
        end
    end

    assign avg_o       = sum_q[9:2];
    assign avg_valid_o = avg_valid_q;

endmodule

// File: rtl/thermostat_ctrl.sv
// ---------------------------------------------------------------------------
// thermostat_ctrl
// Chooses HEAT/COOL/IDLE from the averaged temperature. The choice uses
// hysteresis and a minimum dwell time. The block also drives a slew-limited
// fan duty.
//   clk        : clock, posedge
//   arst       : asynchronous active-low reset
//   enable     : controller enable; low forces IDLE
//   temp_valid : strobe qualifying temp_data
//   temp_data  : unsigned sample, degrees C
//   setpoint   : unsigned target, degrees C
//   chs_conf   : averaged temperature, reloaded on each eligible tick
//   speed      : fan duty for the PWM stage
//   state      : IDLE=0, HEAT=1, COOL=2
//   avg_valid  : four samples accepted since reset
// ---------------------------------------------------------------------------
module thermostat_ctrl
    import chs_pkg::*;
#(
    parameter int unsigned TICK_DIV    = 1000,
    parameter int unsigned HYST        = 2,
    parameter int unsigned DWELL_TICKS = 16,
    parameter int unsigned RAMP_STEP   = 8,
    parameter int unsigned GAIN        = 16
) (
    input  logic       clk,
    input  logic       arst,
    input  logic       enable,
    input  logic       temp_valid,
    input  logic [7:0] temp_data,
    input  logic [7:0] setpoint,
    output logic [7:0] chs_conf,
    output logic [7:0] speed,
    output logic [1:0] state,
    output logic       avg_valid
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int DW = (DWELL_TICKS < 1) ? 1 : $clog2(DWELL_TICKS + 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [DW-1:0] dwell_q, dwell_d;
    chs_state_t    state_q, state_d;
    logic [7:0]    speed_q, speed_d, speed_ramp_s;
    logic [7:0]    chs_q, chs_d;
    logic [7:0]    avg_s, target_s, step_s;
    logic          avg_valid_s, tick_s, eval_s;
    logic [8:0]    sp9_s, avg9_s, lo_s, hi_s;
    logic [15:0]   err_s;

    temp_avg4 u_avg (
        .clk            (clk),
        .arst           (arst),
        .sample_valid_i (temp_valid),
        .sample_i       (temp_data),
        .avg_o          (avg_s),
        .avg_valid_o    (avg_valid_s)
    );

    // Tick prescaler and the saturated hysteresis thresholds.
    always_comb begin
        tick_s  = (presc_q == PW'(TICK_DIV - 1));
        presc_d = tick_s ? {PW{1'b0}} : presc_q + PW'(1);
        eval_s  = tick_s & avg_valid_s;
        sp9_s   = {1'b0, setpoint};
        avg9_s  = {1'b0, avg_s};
        lo_s    = (sp9_s >= 9'(HYST)) ? sp9_s - 9'(HYST) : 9'd0;
        hi_s    = ((sp9_s + 9'(HYST)) > 9'd255) ? 9'd255 : sp9_s + 9'(HYST);
    end

    // FSM state register.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state. Transitions are evaluated only on eligible ticks with the
    // dwell counter expired. A low enable overrides everything.
    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = ST_IDLE;
        end else if (eval_s && (dwell_q == {DW{1'b0}})) begin
            case (state_q)
                ST_IDLE: begin
                    if (avg9_s < lo_s) begin
                        state_d = ST_HEAT;
                    end else if (avg9_s > hi_s) begin
                        state_d = ST_COOL;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_HEAT: state_d = (avg9_s >= sp9_s) ? ST_IDLE : ST_HEAT;
                ST_COOL: state_d = (avg9_s <= sp9_s) ? ST_IDLE : ST_COOL;
                default: state_d = ST_IDLE;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // FSM outputs. The target duty comes from the new-state decision, so the
    // first speed step happens on the same tick as the state change.
    always_comb begin
        err_s = 16'd0;
        case (state_d)
            ST_HEAT: err_s = (setpoint > avg_s) ? {8'd0, setpoint - avg_s} : 16'd0;
            ST_COOL: err_s = (avg_s > setpoint) ? {8'd0, avg_s - setpoint} : 16'd0;
            default: err_s = 16'd0;
        endcase
        target_s = sat_u8(err_s * 16'(GAIN));
    end

    // Dwell counter, slew-limited speed and chs_conf next values.
    always_comb begin
        step_s = 8'(RAMP_STEP);
        if (target_s > speed_q) begin
            speed_ramp_s = ((target_s - speed_q) <= step_s) ? target_s : speed_q + step_s;
        end else begin
            speed_ramp_s = ((speed_q - target_s) <= step_s) ? target_s : speed_q - step_s;
        end
        speed_d = tick_s ? speed_ramp_s : speed_q;
        chs_d   = eval_s ? avg_s : chs_q;
        if (!enable) begin
            dwell_d = {DW{1'b0}};
        end else if (state_d != state_q) begin
            dwell_d = DW'(DWELL_TICKS);
        end else if (tick_s && (dwell_q != {DW{1'b0}})) begin
            dwell_d = dwell_q - DW'(1);
        end else begin
            dwell_d = dwell_q;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            presc_q <= {PW{1'b0}};
            dwell_q <= {DW{1'b0}};
            speed_q <= 8'd0;
            chs_q   <= 8'd0;
        end else begin
            presc_q <= presc_d;
            dwell_q <= dwell_d;
            speed_q <= speed_d;
            chs_q   <= chs_d;
        end
    end

    assign chs_conf  = chs_q;
    assign speed     = speed_q;
    assign state     = state_q;
    assign avg_valid = avg_valid_s;

endmodule

// File: tb/tb_thermostat_ctrl.sv
// Bench for thermostat_ctrl with TICK_DIV=4, DWELL_TICKS=2, HYST=2, RAMP_STEP=8, GAIN=16.
// cyc counts posedges since reset release, so ticks fall on edges where cyc % 4 == 0.
// The stimulus queues the expected outputs for a given edge. The monitor samples 2 time
// units after each posedge and checks every queued entry that is due at that edge.
module tb_thermostat_ctrl;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HEAT = 2'd1;
    localparam logic [1:0] S_COOL = 2'd2;

    typedef struct packed {
        logic [31:0] cyc;
        logic [7:0]  sc;
        logic [1:0]  st;
        logic [7:0]  spd;
        logic [7:0]  chs;
        logic        av;
    } exp_t;

    logic       clk;
    logic       arst;
    logic       enable;
    logic       temp_valid;
    logic [7:0] temp_data;
    logic [7:0] setpoint;
    logic [7:0] chs_conf;
    logic [7:0] speed;
    logic [1:0] state;
    logic       avg_valid;

    int   cyc;
    int   n_cmp;
    int   n_err;
    exp_t exp_q[$];

    thermostat_ctrl #(
        .TICK_DIV    (4),
        .HYST        (2),
        .DWELL_TICKS (2),
        .RAMP_STEP   (8),
        .GAIN        (16)
    ) dut (
        .clk        (clk),
        .arst       (arst),
        .enable     (enable),
        .temp_valid (temp_valid),
        .temp_data  (temp_data),
        .setpoint   (setpoint),
        .chs_conf   (chs_conf),
        .speed      (speed),
        .state      (state),
        .avg_valid  (avg_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count of posedges since the last reset release.
    always @(posedge clk or negedge arst) begin
        if (!arst) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    // Monitor: compare every queued entry that is due at this edge.
    always @(posedge clk) begin
        exp_t e;
        #2;
        while (exp_q.size() > 0 && int'(exp_q[0].cyc) <= cyc) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (int'(e.cyc) != cyc || state !== e.st || speed !== e.spd ||
                chs_conf !== e.chs || avg_valid !== e.av) begin
                n_err++;
                $display("FAIL s%0d_cyc%0d: at cyc %0d got state=%0d speed=%0d chs_conf=%0d avg_valid=%0d, required state=%0d speed=%0d chs_conf=%0d avg_valid=%0d",
                         e.sc, e.cyc, cyc, state, speed, chs_conf, avg_valid,
                         e.st, e.spd, e.chs, e.av);
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached with %0d entries pending", exp_q.size());
        $fatal(1, "watchdog");
    end

    task automatic push(input int c, input int sc, input logic [1:0] st,
                        input int spd, input int chs, input logic av);
        exp_t e;
        e.cyc = 32'(c);
        e.sc  = 8'(sc);
        e.st  = st;
        e.spd = 8'(spd);
        e.chs = 8'(chs);
        e.av  = av;
        exp_q.push_back(e);
    endtask

    task automatic check_now(input string name, input logic [1:0] st, input int spd,
                             input int chs, input logic av);
        n_cmp++;
        if (state !== st || speed !== 8'(spd) || chs_conf !== 8'(chs) || avg_valid !== av) begin
            n_err++;
            $display("FAIL %s: got state=%0d speed=%0d chs_conf=%0d avg_valid=%0d, required state=%0d speed=%0d chs_conf=%0d avg_valid=%0d",
                     name, state, speed, chs_conf, avg_valid, st, spd, chs, av);
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Drive a sample at the current negedge. The DUT accepts it at the next posedge.
    task automatic put_sample(input int v);
        temp_valid = 1'b1;
        temp_data  = 8'(v);
        @(negedge clk);
        temp_valid = 1'b0;
    endtask

    // Four samples at edges c+1..c+4. Callers pick c = tick-1, so the first sample
    // lands on a tick edge and the next tick sees the new average.
    task automatic set_avg(input int c, input int v);
        wait_until(c);
        repeat (4) put_sample(v);
    endtask

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        arst       = 1'b0;
        enable     = 1'b1;
        temp_valid = 1'b0;
        temp_data  = 8'd0;
        setpoint   = 8'd20;
        #2;
        check_now("reset_values", S_IDLE, 0, 0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        arst = 1'b1;

        // 1: fill the averager. Three samples are not enough, and the fourth sets avg_valid.
        push(4, 1, S_IDLE, 0, 0, 1'b0);
        push(5, 1, S_IDLE, 0, 0, 1'b1);
        push(8, 1, S_IDLE, 0, 20, 1'b1);
        repeat (3) put_sample(20);
        wait_until(4);
        put_sample(20);

        // 2: setpoint 25 with avg 20 enters HEAT; target 80 reached in 10 ticks
        wait_until(8);
        setpoint = 8'd25;
        for (int i = 0; i < 10; i++) push(12 + 4*i, 2, S_HEAT, 8*(i+1), 20, 1'b1);

        // 3: tick 52 still sees the old avg; then IDLE, hysteresis hold, HEAT, dwell hold
        push(52, 3, S_HEAT, 80, 20, 1'b1);
        push(56, 3, S_IDLE, 72, 25, 1'b1);
        set_avg(51, 25);
        push(60, 3, S_IDLE, 64, 25, 1'b1);
        push(64, 3, S_IDLE, 56, 23, 1'b1);
        push(68, 3, S_IDLE, 48, 23, 1'b1);
        set_avg(59, 23);
        push(72, 3, S_IDLE, 40, 23, 1'b1);
        push(76, 3, S_HEAT, 48, 22, 1'b1);
        set_avg(71, 22);
        push(80, 3, S_HEAT, 48, 22, 1'b1);
        push(84, 3, S_HEAT, 40, 25, 1'b1);
        push(88, 3, S_IDLE, 32, 25, 1'b1);
        set_avg(79, 25);

        // 4: COOL entered at avg 30, held two ticks after avg returns to 25
        push(92, 4, S_IDLE, 24, 25, 1'b1);
        push(96, 4, S_IDLE, 16, 30, 1'b1);
        push(100, 4, S_COOL, 24, 30, 1'b1);
        set_avg(91, 30);
        push(104, 4, S_COOL, 32, 30, 1'b1);
        push(108, 4, S_COOL, 24, 25, 1'b1);
        push(112, 4, S_IDLE, 16, 25, 1'b1);
        set_avg(103, 25);

        // 5: error 20 saturates the target at 255; then an enable drop ramps down
        push(116, 5, S_IDLE, 8, 25, 1'b1);
        push(120, 5, S_IDLE, 0, 5, 1'b1);
        for (int i = 0; i < 32; i++)
            push(124 + 4*i, 5, S_HEAT, (8*(i+1) > 255) ? 255 : 8*(i+1), 5, 1'b1);
        push(252, 5, S_HEAT, 255, 5, 1'b1);
        set_avg(115, 5);
        wait_until(253);
        enable = 1'b0;
        push(254, 5, S_IDLE, 255, 5, 1'b1);
        for (int j = 0; j < 32; j++)
            push(256 + 4*j, 5, S_IDLE, (255 - 8*(j+1) < 0) ? 0 : 255 - 8*(j+1), 5, 1'b1);
        push(384, 5, S_IDLE, 0, 5, 1'b1);
        push(388, 5, S_IDLE, 0, 0, 1'b1);
        set_avg(383, 0);
        wait_until(388);
        enable   = 1'b1;
        setpoint = 8'd1;
        push(392, 5, S_IDLE, 0, 0, 1'b1);
        push(396, 5, S_IDLE, 0, 0, 1'b1);

        // 6: ramp to 48, then an async reset; the first tick after release comes 4 cycles later
        wait_until(396);
        setpoint = 8'd25;
        for (int i = 0; i < 6; i++) push(400 + 4*i, 6, S_HEAT, 8*(i+1), 0, 1'b1);
        wait_until(420);
        #2;
        arst = 1'b0;
        #1;
        check_now("async_reset_mid_ramp", S_IDLE, 0, 0, 1'b0);
        @(negedge clk);
        arst = 1'b1;
        push(4, 6, S_IDLE, 0, 0, 1'b1);
        push(7, 6, S_IDLE, 0, 0, 1'b1);
        push(8, 6, S_COOL, 8, 30, 1'b1);
        repeat (4) put_sample(30);
        wait_until(10);

        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL pending_entries: got %0d unchecked entries, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/thermostat_ctrl.md
# thermostat_ctrl

Upstream control stage for the cool/heat subsystem. It filters raw temperature samples with a 4-sample moving average and decides HEAT/COOL/IDLE against a setpoint with hysteresis and a minimum dwell time. It drives the degree byte `chs_conf` consumed by the mode/power decoder and a slew-limited fan duty `speed` consumed by the PWM fan stage.

## Interface
Parameters:
- `TICK_DIV`, 1000: clk cycles per control tick (≥2).
- `HYST`, 2: hysteresis band in °C.
- `DWELL_TICKS`, 16: minimum ticks spent in a state before any transition.
- `RAMP_STEP`, 8: maximum `speed` change per tick.
- `GAIN`, 16: target duty per °C of error.

Ports:
- `clk` in 1: clock, posedge.
- `arst` in 1: reset, asynchronous and active-low; all state cleared while low.
- `enable` in 1: controller enable; low forces IDLE.
- `temp_valid` in 1: one-cycle strobe qualifying `temp_data`.
- `temp_data` in 8: unsigned sample, °C.
- `setpoint` in 8: unsigned target, °C; sampled on each tick.
- `chs_conf` out 8: registered averaged temperature for the mode/power decoder.
- `speed` out 8: fan duty for the PWM stage.
- `state` out 2: IDLE=0, HEAT=1, COOL=2.
- `avg_valid` out 1: high once 4 samples have been accepted since reset.

## Operation
- **Averager.** Each `temp_valid` shifts `temp_data` into a 4-deep buffer. The 10-bit sum is registered, and `avg = sum >> 2` (truncating). The sample count saturates at 4, and `avg_valid` rises in the cycle after the 4th strobe.
- **Prescaler.** The counter runs 0..TICK_DIV-1. `tick` pulses for one cycle when the count equals TICK_DIV-1, then the counter wraps to 0.
- **Per-tick evaluation.** All decisions happen on a tick, and only when `avg_valid`=1. The evaluation uses the registered `avg` as it stands before any sample accepted in the same cycle.
- **chs_conf.** Loaded with `avg` on every tick while `avg_valid`.
- **Thresholds.** `lo = max(setpoint-HYST, 0)` and `hi = min(setpoint+HYST, 255)`. Both are computed 9-bit with saturation.
- **FSM transitions** (blocked while `dwell_cnt` ≠ 0):
  - IDLE→HEAT if `avg < lo`.
  - IDLE→COOL if `avg > hi`.
  - HEAT→IDLE if `avg ≥ setpoint`.
  - COOL→IDLE if `avg ≤ setpoint`.
  - No direct HEAT↔COOL transition.
- **Dwell counter.** Loaded with DWELL_TICKS on every state entry. It decrements on each tick while nonzero.
- **enable low.** State goes to IDLE in the next cycle, regardless of tick or dwell, and the dwell counter is cleared. `speed` still ramps down per tick; it does not drop instantly.
- **Target duty.**
  - IDLE: 0.
  - HEAT: `min((setpoint-avg)*GAIN, 255)`.
  - COOL: `min((avg-setpoint)*GAIN, 255)`.
  - Use 16-bit intermediate arithmetic and floor the error at 0.
- **Speed ramp.** On each tick, `speed` moves toward target by at most RAMP_STEP and never overshoots, i.e. `speed = target` if `|target-speed| ≤ RAMP_STEP`.

## Timing
- **Reset values:** `chs_conf`=0, `speed`=0, `state`=IDLE, `avg_valid`=0. Prescaler, dwell counter, sample count and buffer are all 0.
- **Latency:**
  - Sample to registered `avg`: 1 cycle.
  - `avg` to `chs_conf`/`state`: next tick.
  - `state` change to the first `speed` step: the same tick, because target is computed combinationally from the new-state decision.
- **Reset mid-operation:** everything returns to reset values asynchronously. The first tick after release occurs TICK_DIV cycles later.
- **temp_valid on every cycle:** fully supported, with no backpressure.

## Structure
- **Shared package `chs_pkg`:** state encoding constants (`ST_IDLE`, `ST_HEAT`, `ST_COOL`) and the 2-bit state type. Shared with the mode/power decoder.
- **Sub-module `temp_avg4`:** buffer, sum, `avg`, `avg_valid`.
- **Top level:** prescaler, FSM, dwell counter and ramp.

## Test plan
All scenarios use TICK_DIV=4, DWELL_TICKS=2, HYST=2, RAMP_STEP=8, GAIN=16.
1. **Reset and fill.** Pulse `arst` low, then feed 3 samples of 20.
   - Required: `avg_valid`=0, `state`=IDLE, `speed`=0.
   - After a 4th sample: `avg_valid`=1, and `chs_conf`=20 on the next tick.
2. **Heat entry and ramp.** Setpoint 25, samples all 20.
   - Required: state goes IDLE→HEAT on the first eligible tick; target 80.
   - `speed` steps 8, 16, … and reaches 80 after 10 ticks.
3. **Hysteresis.** Setpoint 25, avg 23.
   - Required: stays IDLE.
   - When avg drops to 22, enters HEAT.
   - Returns to IDLE only once avg ≥25, and not before 2 ticks have elapsed.
4. **Dwell blocking.** Enter COOL with avg 30 and setpoint 25, then immediately set avg to 25.
   - Required: state remains COOL for 2 ticks, then goes IDLE.
5. **Enable drop and saturation.** In HEAT, drop `enable`.
   - Required: IDLE next cycle; `speed` decreases by 8 per tick to 0.
   - Setpoint 1 with `HYST` saturation gives `lo`=0, so no HEAT is ever entered.
   - Error 20 gives target saturated at 255.
6. **Async reset mid-ramp.** Assert `arst` low while `speed`=48.
   - Required: `speed`=0, `state`=IDLE and `chs_conf`=0 immediately, without waiting for a clk edge.
